// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// drives the IF/ID pipeline register, with a one-entry buffer for IF/ID stalls.
//   state  | meaning
//   IDLE   | just out of reset, nothing requested yet
//   WAIT   | fetch outstanding, waiting for mem_ack
//   HOLD   | fetched word parked in buffer while IF/ID is stalled
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [4:0]  stall_cmd,
    input  logic        br_flag,
    input  logic [31:0] br_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        if_stall_req,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] buf_inst, buf_inst_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic        discard, discard_n;
    logic        mem_req_n;
    logic [31:0] mem_addr_n;
    logic [31:0] id_pc_n, id_inst_n;
    logic        id_valid_n;

    logic        redir;
    logic [31:0] tgt;
    logic [31:0] pc_inc;
    logic        deliver;
    logic [31:0] dl_pc, dl_inst;

    // stall_cmd[0] is implied by if_stall_req; [4:3] belong to later stages.
    logic unused_bits;
    assign unused_bits = ^{stall_cmd[4:3], stall_cmd[0], br_target[1:0]};

    assign redir  = br_flag & ~stall_cmd[2];
    assign tgt    = {br_target[31:2], 2'b00};
    assign pc_inc = pc + 32'd4;

    assign if_stall_req = ~rst & (state != S_HOLD);

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        buf_inst_n = buf_inst;
        buf_pc_n   = buf_pc;
        discard_n  = discard;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        id_pc_n    = id_pc;
        id_inst_n  = id_inst;
        id_valid_n = id_valid;
        deliver    = 1'b0;
        dl_pc      = pc;
        dl_inst    = mem_data;

        case (state)
            S_IDLE: begin
                state_n   = S_WAIT;
                mem_req_n = 1'b1;
                if (redir) begin
                    pc_n       = tgt;
                    mem_addr_n = tgt;
                end else begin
                    mem_addr_n = pc;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    if (discard || redir) begin
                        // wrong-path word: drop it and refetch without a gap
                        discard_n  = 1'b0;
                        pc_n       = redir ? tgt : pc;
                        mem_addr_n = redir ? tgt : pc;
                    end else if (!stall_cmd[1]) begin
                        deliver    = 1'b1;
                        pc_n       = pc_inc;
                        mem_addr_n = pc_inc;
                    end else begin
                        buf_pc_n   = pc;
                        buf_inst_n = mem_data;
                        pc_n       = pc_inc;
                        mem_req_n  = 1'b0;
                        state_n    = S_HOLD;
                    end
                end else if (redir) begin
                    // request stays on the bus; its data is discarded later
                    pc_n      = tgt;
                    discard_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_n       = tgt;
                    mem_req_n  = 1'b1;
                    mem_addr_n = tgt;
                    state_n    = S_WAIT;
                end else if (!stall_cmd[1]) begin
                    deliver    = 1'b1;
                    dl_pc      = buf_pc;
                    dl_inst    = buf_inst;
                    mem_req_n  = 1'b1;
                    mem_addr_n = pc;
                    state_n    = S_WAIT;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (redir) begin
            id_inst_n  = NOP_INST;
            id_valid_n = 1'b0;
        end else if (deliver) begin
            id_pc_n    = dl_pc;
            id_inst_n  = dl_inst;
            id_valid_n = 1'b1;
        end else if (!stall_cmd[1]) begin
            id_inst_n  = NOP_INST;
            id_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            buf_inst <= NOP_INST;
            buf_pc   <= 32'd0;
            discard  <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= 32'd0;
            id_pc    <= 32'd0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (rdy) begin
            state    <= state_n;
            pc       <= pc_n;
            buf_inst <= buf_inst_n;
            buf_pc   <= buf_pc_n;
            discard  <= discard_n;
            mem_req  <= mem_req_n;
            mem_addr <= mem_addr_n;
            id_pc    <= id_pc_n;
            id_inst  <= id_inst_n;
            id_valid <= id_valid_n;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then random
// stimulus, all compared every cycle against a fetch-level reference model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [4:0]  stall_cmd = 5'd0;
    logic        br_flag = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        if_stall_req;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // memory responder settings
    bit mem_auto = 1'b1;
    int mem_lat = 0;
    int wcnt = 0;

    // reference model of the fetch stage as seen from outside
    bit          m_fresh, m_buffered, m_wrong, m_req, m_id_valid;
    logic [31:0] m_pc, m_addr, m_buf_pc, m_buf_inst, m_id_pc, m_id_inst;

    if_stage dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_cmd(stall_cmd),
        .br_flag(br_flag), .br_target(br_target),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .if_stall_req(if_stall_req),
        .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic        redir;
        logic [31:0] tgt;
        bit          got;
        logic [31:0] g_pc, g_inst;
        redir  = br_flag && !stall_cmd[2];
        tgt    = {br_target[31:2], 2'b00};
        got    = 1'b0;
        g_pc   = 32'd0;
        g_inst = 32'd0;
        if (rst) begin
            m_fresh = 1'b1; m_buffered = 1'b0; m_wrong = 1'b0;
            m_pc = 32'd0; m_req = 1'b0; m_addr = 32'd0;
            m_id_pc = 32'd0; m_id_inst = NOP; m_id_valid = 1'b0;
        end else if (rdy) begin
            if (m_fresh) begin
                m_fresh = 1'b0;
                if (redir) m_pc = tgt;
                m_req = 1'b1; m_addr = m_pc;
            end else if (m_buffered) begin
                if (redir) begin
                    m_buffered = 1'b0; m_pc = tgt; m_req = 1'b1; m_addr = m_pc;
                end else if (!stall_cmd[1]) begin
                    m_buffered = 1'b0; got = 1'b1; g_pc = m_buf_pc; g_inst = m_buf_inst;
                    m_req = 1'b1; m_addr = m_pc;
                end
            end else if (mem_ack) begin
                if (m_wrong || redir) begin
                    m_wrong = 1'b0;
                    if (redir) m_pc = tgt;
                    m_addr = m_pc;
                end else if (!stall_cmd[1]) begin
                    got = 1'b1; g_pc = m_pc; g_inst = mem_data;
                    m_pc = m_pc + 32'd4; m_addr = m_pc;
                end else begin
                    m_buf_pc = m_pc; m_buf_inst = mem_data;
                    m_pc = m_pc + 32'd4; m_buffered = 1'b1; m_req = 1'b0;
                end
            end else if (redir) begin
                m_pc = tgt; m_wrong = 1'b1;
            end
            if (redir) begin
                m_id_inst = NOP; m_id_valid = 1'b0;
            end else if (got) begin
                m_id_pc = g_pc; m_id_inst = g_inst; m_id_valid = 1'b1;
            end else if (!stall_cmd[1]) begin
                m_id_inst = NOP; m_id_valid = 1'b0;
            end
        end
    endtask

    // drive memory response, clock once, advance the model, settle
    task automatic step();
        if (mem_auto) begin
            if (rst) begin
                mem_ack = 1'b0; wcnt = 0;
            end else if (rdy && mem_req) begin
                if (wcnt >= mem_lat) begin
                    mem_ack = 1'b1; mem_data = mem_word(mem_addr); wcnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_data = $urandom; wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                if (!mem_req) wcnt = 0;
            end
        end
        @(posedge clk);
        model_update();
        #2;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check1("mem_req", mem_req, m_req);
                check("mem_addr", mem_addr, m_addr);
                check1("if_stall_req", if_stall_req, !rst && !m_buffered);
                check("id_pc", id_pc, m_id_pc);
                check("id_inst", id_inst, m_id_inst);
                check1("id_valid", id_valid, m_id_valid);
            end
        end
    end

    initial begin
        int nv;
        int n;
        bit saw;
        bit got;
        bit addr_seen;
        logic [31:0] first;

        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        check1("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_inst", id_inst, NOP);
        check1("rst_id_valid", id_valid, 1'b0);
        check1("rst_stall_req", if_stall_req, 1'b0);

        // zero-wait memory
        rst = 1'b0;
        step();
        check1("first_req", mem_req, 1'b1);
        check("first_addr", mem_addr, 32'd0);
        check1("first_stall_req", if_stall_req, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("zw_id_pc", id_pc, 32'(4 * k));
            check1("zw_id_valid", id_valid, 1'b1);
        end

        // three-cycle latency: one instruction every four edges
        mem_lat = 3;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (id_valid) nv++;
        end
        check("lat3_count", 32'(nv), 32'd5);

        // IF/ID stall while an ack arrives
        rst = 1'b1; step();
        rst = 1'b0; mem_lat = 0;
        step(); step();
        check("hold_pre_pc", id_pc, 32'd0);
        stall_cmd = 5'b00011;
        step();
        check1("hold_mem_req", mem_req, 1'b0);
        check("hold_id_pc", id_pc, 32'd0);
        check("hold_id_inst", id_inst, mem_word(32'd0));
        check1("hold_stall_req", if_stall_req, 1'b0);
        step(); step();
        check("hold_keep_pc", id_pc, 32'd0);
        stall_cmd = 5'b00000;
        step();
        check("rel_id_pc", id_pc, 32'd4);
        check("rel_id_inst", id_inst, mem_word(32'd4));
        check1("rel_id_valid", id_valid, 1'b1);
        check1("rel_mem_req", mem_req, 1'b1);
        check("rel_mem_addr", mem_addr, 32'd8);

        // redirect while the fetch of 0x20 is outstanding
        mem_lat = 3;
        n = 0;
        while (mem_addr !== 32'h20 && n < 200) begin
            step();
            n++;
        end
        check("br_reach", mem_addr, 32'h20);
        br_flag = 1'b1; br_target = 32'h101;
        step();
        br_flag = 1'b0;
        check1("br_flush_valid", id_valid, 1'b0);
        check("br_flush_inst", id_inst, NOP);
        check("br_hold_addr", mem_addr, 32'h20);
        saw = 1'b0; got = 1'b0; addr_seen = 1'b0; first = 32'hFFFF_FFFF;
        for (int k = 0; k < 30; k++) begin
            step();
            if (id_valid && id_pc == 32'h20) saw = 1'b1;
            if (!addr_seen && mem_addr !== 32'h20) begin
                addr_seen = 1'b1;
                check("br_reissue_addr", mem_addr, 32'h100);
            end
            if (id_valid && !got) begin
                got = 1'b1;
                first = id_pc;
            end
            if (got) break;
        end
        check("br_first_pc", first, 32'h100);
        check1("br_no_wrong_path", saw, 1'b0);

        // redirect masked by stall_cmd[2]
        stall_cmd = 5'b00100; br_flag = 1'b1; br_target = 32'h200;
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (mem_addr == 32'h200 || (id_valid && id_pc == 32'h200)) saw = 1'b1;
        end
        br_flag = 1'b0; stall_cmd = 5'b00000;
        for (int k = 0; k < 8; k++) begin
            step();
            if (mem_addr == 32'h200 || (id_valid && id_pc == 32'h200)) saw = 1'b1;
        end
        check1("gated_br_ignored", saw, 1'b0);

        // PC wrap at the top of the address space
        mem_lat = 0;
        br_flag = 1'b1; br_target = 32'hFFFF_FFFF;
        step();
        br_flag = 1'b0;
        n = 0;
        while (!(id_valid && id_pc == 32'hFFFF_FFFC) && n < 50) begin
            step();
            n++;
        end
        check("wrap_reach", id_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", id_pc, 32'd0);
        check1("wrap_valid", id_valid, 1'b1);

        // reset during an outstanding fetch, stray ack just after release
        mem_lat = 3;
        step(); step();
        rst = 1'b1;
        step();
        check1("rst_mid_req", mem_req, 1'b0);
        check1("rst_mid_stall_req", if_stall_req, 1'b0);
        rst = 1'b0;
        mem_auto = 1'b0; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        check1("stray_ack_valid", id_valid, 1'b0);
        check1("stray_ack_req", mem_req, 1'b1);
        check("stray_ack_addr", mem_addr, 32'd0);
        mem_auto = 1'b1; wcnt = 0; mem_lat = 0;
        step();
        check("post_rst_pc", id_pc, 32'd0);
        check("post_rst_inst", id_inst, mem_word(32'd0));
        check1("post_rst_valid", id_valid, 1'b1);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            stall_cmd = {2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                         ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
            br_flag = ($urandom_range(0, 9) == 0);
            br_target = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) mem_lat = $urandom_range(0, 3);
            step();
        end

        rst = 1'b0; rdy = 1'b1; stall_cmd = 5'd0; br_flag = 1'b0;
        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
